// File: rtl/div_pkg.sv
// Shared widths, FSM state type and sign helpers for the iterative divider.
package div_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] abs_val(input logic sgn, input logic [XLEN-1:0] v);
    return (sgn && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step on the {partial remainder, quotient} register.
module div_step
  import div_pkg::*;
(
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   divisor_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   trial;
  logic [XLEN-1:0] diff;

  // trial is the shifted-up remainder including the carried-out MSB, so the
  // compare stays exact even when the remainder temporarily needs 65 bits.
  always_comb begin
    trial = acc_i[2*XLEN-1:XLEN-1];
    diff  = trial[XLEN-1:0] - divisor_i;
    if (trial >= {1'b0, divisor_i}) begin
      acc_o = {diff, acc_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {acc_i[2*XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div.sv
// 64-bit signed/unsigned restoring divider, one quotient bit per cycle.
// Define DIV_ZERO_FAST_EN to complete divide-by-zero straight from IDLE.
//
// state  | meaning
// S_IDLE | waiting for a request, div_ready high
// S_BUSY | 64 shift-subtract steps in progress
// S_DONE | result held until out_ready
module div
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            div_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*XLEN-1:0]  acc_q, acc_d, acc_step;
  logic [XLEN-1:0]    dvsr_q, dvsr_d;
  logic [XLEN-1:0]    dvnd_q, dvnd_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               zero_q, zero_d;
  logic [XLEN-1:0]    quo_q, quo_d;
  logic [XLEN-1:0]    rem_q, rem_d;
  logic               accept;
  logic               last_step;

  div_step u_step (
    .acc_i     (acc_q),
    .divisor_i (dvsr_q),
    .acc_o     (acc_step)
  );

  assign accept    = div_valid && (state_q == S_IDLE) && !flush;
  assign last_step = (state_q == S_BUSY) && (cnt_q == CNT_W'(XLEN-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef DIV_ZERO_FAST_EN
          state_d = (divisor == '0) ? S_DONE : S_BUSY;
`else
          state_d = S_BUSY;
`endif
        end
      end
      S_BUSY:  if (last_step) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    div_ready = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvsr_d  = dvsr_q;
    dvnd_d  = dvnd_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    zero_d  = zero_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    if (accept) begin
      cnt_d   = '0;
      acc_d   = {{XLEN{1'b0}}, abs_val(div_signed, dividend)};
      dvsr_d  = abs_val(div_signed, divisor);
      dvnd_d  = dividend;
      neg_q_d = div_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
      neg_r_d = div_signed && dividend[XLEN-1];
      zero_d  = (divisor == '0);
`ifdef DIV_ZERO_FAST_EN
      if (divisor == '0) begin
        quo_d = '1;
        rem_d = dividend;
      end
`endif
    end else if ((state_q == S_BUSY) && !flush) begin
      acc_d = acc_step;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_step) begin
        // The raw step result for a zero divisor is meaningless; substitute the defined values.
        quo_d = zero_q ? '1     : cond_neg(neg_q_q, acc_step[XLEN-1:0]);
        rem_d = zero_q ? dvnd_q : cond_neg(neg_r_q, acc_step[2*XLEN-1:XLEN]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      dvsr_q  <= '0;
      dvnd_q  <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      zero_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dvsr_q  <= dvsr_d;
      dvnd_q  <= dvnd_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      zero_q  <= zero_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus random operands
// checked against an arithmetic reference model.
module tb_div;

  logic        clk = 1'b0;
  logic        rst, flush, div_valid, div_ready, div_signed;
  logic [63:0] dividend, divisor, quotient, remainder;
  logic        out_valid, out_ready;

  int n_vec = 0;
  int n_err = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST_ZERO = 1'b1;
`else
  localparam bit FAST_ZERO = 1'b0;
`endif

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  always #5 clk = ~clk;

  div dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input bit sgn, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] q, output logic [63:0] r);
    longint sa, sb;
    sa = a;
    sb = b;
    if (b == 64'd0) begin
      q = '1;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == MIN64 && b == '1) begin
      q = MIN64;
      r = 64'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom} >> $urandom_range(0, 63);
  endfunction

  // Issue one request, check latency and result, hold the result for `hold`
  // cycles with out_ready low, then hand it off and check the return to IDLE.
  task automatic run_op(input bit sgn, input logic [63:0] a, input logic [63:0] b, input int hold);
    logic [63:0] eq, er;
    int cyc;
    bit seen;
    model(sgn, a, b, eq, er);
    @(negedge clk);
    chk("ready_before", 64'(div_ready), 64'd1);
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    div_valid  = 1'b1;
    out_ready  = 1'b0;
    @(posedge clk);
    #1;
    dividend   = {$urandom, $urandom};
    divisor    = {$urandom, $urandom};
    div_signed = 1'($urandom);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 200 && !seen) begin
      @(negedge clk);
      cyc++;
      if (out_valid) seen = 1'b1;
    end
    div_valid = 1'b0;
    chk("latency", 64'(cyc), (FAST_ZERO && b == 64'd0) ? 64'd1 : 64'd65);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_quotient", quotient, eq);
      chk("hold_remainder", remainder, er);
      chk("hold_ready_valid", {62'd0, div_ready, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_out_valid", 64'(out_valid), 64'd0);
    chk("post_ready", 64'(div_ready), 64'd1);
  endtask

  initial begin
    int highs;
    bit sgn;
    logic [63:0] a, b;

    rst = 1'b1; flush = 1'b0; div_valid = 1'b0; div_signed = 1'b0;
    dividend = '0; divisor = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(div_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quotient", quotient, 64'd0);
    chk("rst_remainder", remainder, 64'd0);

    run_op(1'b0, 64'd100, 64'd7, 0);
    run_op(1'b1, -64'sd7, 64'd2, 0);
    run_op(1'b1, 64'd5, 64'd0, 0);
    run_op(1'b0, 64'd5, 64'd0, 0);
    run_op(1'b1, MIN64, '1, 0);
    run_op(1'b0, 64'd1000, 64'd33, 10);

    // flush 30 cycles into BUSY: back to IDLE, result never appears
    @(negedge clk);
    div_signed = 1'b0; dividend = 64'd123456; divisor = 64'd7; div_valid = 1'b1;
    @(posedge clk);
    #1 div_valid = 1'b0;
    repeat (30) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy_valid", 64'(out_valid), 64'd0);
    chk("flush_busy_ready", 64'(div_ready), 64'd1);
    highs = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) highs++;
    end
    chk("flush_no_output", 64'(highs), 64'd0);
    run_op(1'b0, 64'd9, 64'd3, 0);

    // flush beats a simultaneous request in IDLE
    @(negedge clk);
    flush = 1'b1; div_valid = 1'b1; dividend = 64'd50; divisor = 64'd5;
    @(posedge clk);
    #1 flush = 1'b0; div_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle_ready", 64'(div_ready), 64'd1);
    chk("flush_idle_valid", 64'(out_valid), 64'd0);

    // flush beats the result handshake in DONE
    @(negedge clk);
    div_signed = 1'b0; dividend = 64'd77; divisor = 64'd11; div_valid = 1'b1;
    @(posedge clk);
    #1 div_valid = 1'b0;
    repeat (66) @(negedge clk);
    chk("done_reached", 64'(out_valid), 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; out_ready = 1'b0;
    chk("flush_done_valid", 64'(out_valid), 64'd0);
    chk("flush_done_ready", 64'(div_ready), 64'd1);

    // reset mid-BUSY drops the operation and clears outputs
    @(negedge clk);
    div_signed = 1'b1; dividend = 64'd999; divisor = 64'd4; div_valid = 1'b1;
    @(posedge clk);
    #1 div_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    highs = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) highs++;
    end
    chk("rst_busy_no_output", 64'(highs), 64'd0);
    chk("rst_busy_ready", 64'(div_ready), 64'd1);
    chk("rst_busy_quotient", quotient, 64'd0);
    chk("rst_busy_remainder", remainder, 64'd0);

    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom);
      a = $urandom_range(0, 1) ? rnd64() : -rnd64();
      b = rnd64() >> $urandom_range(0, 40);
      if ($urandom_range(0, 7) == 0) b = 64'd0;
      if ($urandom_range(0, 1) == 0 && sgn) b = -b;
      if ($urandom_range(0, 15) == 0) begin
        sgn = 1'b1; a = MIN64; b = '1;
      end
      run_op(sgn, a, b, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
